// File: rtl/ps2_scancode_decoder_pkg.sv
// Shared PS/2 set-2 scancode and key-event constants plus the prefix FSM state type.
// Used by the scancode decoder top and its interface.
package ps2_pkg;
    localparam logic [7:0] SC_BREAK  = 8'hF0;
    localparam logic [7:0] SC_EXT    = 8'hE0;
    localparam logic [7:0] SC_LSHIFT = 8'h12;
    localparam logic [7:0] SC_RSHIFT = 8'h59;
    localparam logic [7:0] SC_CAPS   = 8'h58;
    localparam logic [7:0] SC_BAT_OK = 8'hAA;
    localparam logic [7:0] SC_ACK    = 8'hFA;
    localparam logic [7:0] SC_ECHO   = 8'hEE;
    localparam logic [7:0] SC_RESEND = 8'hFE;

    localparam logic [7:0] EV_UP     = 8'h80;
    localparam logic [7:0] EV_DOWN   = 8'h81;
    localparam logic [7:0] EV_LEFT   = 8'h82;
    localparam logic [7:0] EV_RIGHT  = 8'h83;
    localparam logic [7:0] ASC_CR    = 8'h0D;
    localparam logic [7:0] ASC_BS    = 8'h08;
    localparam logic [7:0] ASC_TAB   = 8'h09;
    localparam logic [7:0] ASC_ESC   = 8'h1B;
    localparam logic [7:0] ASC_SPACE = 8'h20;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_BRK,
        ST_EXT,
        ST_EXT_BRK
    } pfx_state_t;
endpackage

// File: rtl/ps2_scancode_decoder_if.sv
// Scancode input, key-event valid/ready output and status bundle of the decoder.
// master = decoder side, slave = keyboard controller / consumer side.
interface ps2_scancode_decoder_if #(
    parameter int FIFO_DEPTH = 8
);
    logic [7:0]                   scan_data;
    logic                         scan_valid;
    logic [7:0]                   key_ascii;
    logic                         key_valid;
    logic                         key_ready;
    logic                         shift_state;
    logic                         caps_state;
    logic [$clog2(FIFO_DEPTH):0]  fifo_count;
    logic                         overflow;

    modport master (
        input  scan_data, scan_valid, key_ready,
        output key_ascii, key_valid, shift_state, caps_state, fifo_count, overflow
    );

    modport slave (
        output scan_data, scan_valid, key_ready,
        input  key_ascii, key_valid, shift_state, caps_state, fifo_count, overflow
    );
endinterface

// File: rtl/ps2_scancode_decoder_key_fifo.sv
// Show-ahead synchronous FIFO; read data is combinational from the head, 0 when empty.
// Latency 1 clk push->visible; push while full succeeds only if a pop happens on the same edge.
module ps2_key_fifo #(
    parameter int DEPTH = 8,
    parameter int WIDTH = 8
) (
    input  logic                     clock,
    input  logic                     resetn,
    input  logic                     push,
    input  logic [WIDTH-1:0]         push_dat,
    input  logic                     pop,
    output logic [WIDTH-1:0]         pop_dat,
    output logic                     full,
    output logic                     empty,
    output logic [$clog2(DEPTH):0]   count
);
    localparam int AW = $clog2(DEPTH);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW-1:0]    wr_ptr;
    logic [AW-1:0]    rd_ptr;
    logic             push_ok;
    logic             pop_ok;

    assign empty   = (count == '0);
    assign full    = (count == DEPTH[AW:0]);
    assign pop_ok  = pop && !empty;
    assign push_ok = push && (!full || pop_ok);
    assign pop_dat = empty ? '0 : mem[rd_ptr];

    always_ff @(posedge clock) begin
        if (push_ok) begin
            mem[wr_ptr] <= push_dat;
        end
    end

    always_ff @(posedge clock) begin
        if (!resetn) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (push_ok) wr_ptr <= wr_ptr + 1'b1;
            if (pop_ok)  rd_ptr <= rd_ptr + 1'b1;
            if (push_ok && !pop_ok)      count <= count + 1'b1;
            else if (pop_ok && !push_ok) count <= count - 1'b1;
        end
    end
endmodule

// File: rtl/ps2_scancode_decoder.sv
// PS/2 set-2 bytes -> ASCII key events in a FIFO; 2 clk scan->key_valid; key_ready stalls, full FIFO drops + sticky overflow.
// Caps-lock tracking only when PS2_CAPSLOCK_EN is defined.
module ps2_scancode_decoder
    import ps2_pkg::*;
#(
    parameter int FIFO_DEPTH = 8
) (
    input  logic                   clock,
    input  logic                   resetn,
    ps2_scancode_decoder_if.master kb
);
    pfx_state_t state_q, state_d;
    logic       lsh_q, lsh_d, rsh_q, rsh_d;
    logic       caps_q;
    logic       is_make, is_break, is_ext;
    logic [8:0] xl;
    logic       evt_vld_q, evt_vld_d;
    logic [7:0] evt_dat_q;
    logic       overflow_q;
    logic       fifo_full, fifo_empty, pop;

    // Returns {hit, code}; shifted applies only to digits, upper only to letters.
    function automatic logic [8:0] translate(input logic [7:0] code, input logic ext,
                                             input logic upper, input logic shifted);
        logic [7:0] ch;
        logic       hit;
        ch  = 8'h00;
        hit = 1'b1;
        if (ext) begin
            case (code)
                8'h75:   ch = EV_UP;
                8'h72:   ch = EV_DOWN;
                8'h6B:   ch = EV_LEFT;
                8'h74:   ch = EV_RIGHT;
                default: hit = 1'b0;
            endcase
        end else begin
            case (code)
                8'h1C: ch = "a";  8'h32: ch = "b";  8'h21: ch = "c";  8'h23: ch = "d";
                8'h24: ch = "e";  8'h2B: ch = "f";  8'h34: ch = "g";  8'h33: ch = "h";
                8'h43: ch = "i";  8'h3B: ch = "j";  8'h42: ch = "k";  8'h4B: ch = "l";
                8'h3A: ch = "m";  8'h31: ch = "n";  8'h44: ch = "o";  8'h4D: ch = "p";
                8'h15: ch = "q";  8'h2D: ch = "r";  8'h1B: ch = "s";  8'h2C: ch = "t";
                8'h3C: ch = "u";  8'h2A: ch = "v";  8'h1D: ch = "w";  8'h22: ch = "x";
                8'h35: ch = "y";  8'h1A: ch = "z";
                8'h45: ch = "0";  8'h16: ch = "1";  8'h1E: ch = "2";  8'h26: ch = "3";
                8'h25: ch = "4";  8'h2E: ch = "5";  8'h36: ch = "6";  8'h3D: ch = "7";
                8'h3E: ch = "8";  8'h46: ch = "9";
                8'h29: ch = ASC_SPACE;
                8'h5A: ch = ASC_CR;
                8'h66: ch = ASC_BS;
                8'h0D: ch = ASC_TAB;
                8'h76: ch = ASC_ESC;
                SC_BAT_OK, SC_ACK, SC_ECHO, SC_RESEND: hit = 1'b0;
                default: hit = 1'b0;
            endcase
            if (ch >= "a" && ch <= "z") begin
                if (upper) ch = ch - 8'h20;
            end else if (shifted) begin
                case (ch)
                    "0": ch = ")";  "1": ch = "!";  "2": ch = "@";  "3": ch = "#";
                    "4": ch = "$";  "5": ch = "%";  "6": ch = "^";  "7": ch = "&";
                    "8": ch = "*";  "9": ch = "(";
                    default: ;
                endcase
            end
        end
        return {hit, ch};
    endfunction

`ifdef PS2_CAPSLOCK_EN
    logic caps_d;
    always_ff @(posedge clock) begin
        if (!resetn) caps_q <= 1'b0;
        else         caps_q <= caps_d;
    end
`else
    assign caps_q = 1'b0;
`endif

    always_comb begin
        state_d  = state_q;
        lsh_d    = lsh_q;
        rsh_d    = rsh_q;
        is_make  = 1'b0;
        is_break = 1'b0;
        is_ext   = 1'b0;
`ifdef PS2_CAPSLOCK_EN
        caps_d   = caps_q;
`endif
        if (kb.scan_valid) begin
            case (state_q)
                ST_IDLE: begin
                    if (kb.scan_data == SC_BREAK)    state_d = ST_BRK;
                    else if (kb.scan_data == SC_EXT) state_d = ST_EXT;
                    else                             is_make = 1'b1;
                end
                ST_BRK: begin
                    is_break = 1'b1;
                    state_d  = ST_IDLE;
                end
                ST_EXT: begin
                    if (kb.scan_data == SC_BREAK) begin
                        state_d = ST_EXT_BRK;
                    end else begin
                        is_make = 1'b1;
                        is_ext  = 1'b1;
                        state_d = ST_IDLE;
                    end
                end
                ST_EXT_BRK: begin
                    is_break = 1'b1;
                    is_ext   = 1'b1;
                    state_d  = ST_IDLE;
                end
                default: state_d = ST_IDLE;
            endcase
        end

        // Uses pre-edge modifier state; the key that changes it emits nothing.
        xl = translate(kb.scan_data, is_ext, (lsh_q | rsh_q) ^ caps_q, lsh_q | rsh_q);
        evt_vld_d = is_make && xl[8];

        if (is_make && !is_ext) begin
            if (kb.scan_data == SC_LSHIFT) lsh_d = 1'b1;
            if (kb.scan_data == SC_RSHIFT) rsh_d = 1'b1;
`ifdef PS2_CAPSLOCK_EN
            if (kb.scan_data == SC_CAPS)   caps_d = !caps_q;
`endif
        end
        if (is_break && !is_ext) begin
            if (kb.scan_data == SC_LSHIFT) lsh_d = 1'b0;
            if (kb.scan_data == SC_RSHIFT) rsh_d = 1'b0;
        end
    end

    always_ff @(posedge clock) begin
        if (!resetn) begin
            state_q    <= ST_IDLE;
            lsh_q      <= 1'b0;
            rsh_q      <= 1'b0;
            evt_vld_q  <= 1'b0;
            evt_dat_q  <= 8'h00;
            overflow_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            lsh_q     <= lsh_d;
            rsh_q     <= rsh_d;
            evt_vld_q <= evt_vld_d;
            evt_dat_q <= xl[7:0];
            if (evt_vld_q && fifo_full && !pop) overflow_q <= 1'b1;
        end
    end

    assign pop = kb.key_valid && kb.key_ready;

    ps2_key_fifo #(
        .DEPTH (FIFO_DEPTH),
        .WIDTH (8)
    ) u_fifo (
        .clock    (clock),
        .resetn   (resetn),
        .push     (evt_vld_q),
        .push_dat (evt_dat_q),
        .pop      (pop),
        .pop_dat  (kb.key_ascii),
        .full     (fifo_full),
        .empty    (fifo_empty),
        .count    (kb.fifo_count)
    );

    assign kb.key_valid   = !fifo_empty;
    assign kb.shift_state = lsh_q | rsh_q;
    assign kb.caps_state  = caps_q;
    assign kb.overflow    = overflow_q;
endmodule

// File: tb/tb_ps2_scancode_decoder.sv
// Scoreboard bench for ps2_scancode_decoder: expected events queued at stimulus, compared on pop.
module tb_ps2_scancode_decoder;
    logic clock = 1'b0;
    logic resetn;
    int   err_cnt = 0;
    int   chk_cnt = 0;
    logic [7:0] exp_q[$];

    ps2_scancode_decoder_if #(.FIFO_DEPTH(8)) bus ();

    ps2_scancode_decoder #(.FIFO_DEPTH(8)) dut (
        .clock  (clock),
        .resetn (resetn),
        .kb     (bus)
    );

    always #5 clock = ~clock;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        chk_cnt++;
        if (got !== exp) begin
            err_cnt++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
        end
    endtask

    // Called at posedge+1; leaves at the following posedge+1 with scan_valid low.
    task automatic send(input logic [7:0] b);
        bus.scan_data  = b;
        bus.scan_valid = 1'b1;
        @(posedge clock);
        #1;
        bus.scan_valid = 1'b0;
    endtask

    task automatic expect_send(input logic [7:0] b, input logic [7:0] ev);
        exp_q.push_back(ev);
        send(b);
    endtask

    task automatic drain(input string tag);
        for (int i = 0; i < 64 && (exp_q.size() != 0 || bus.key_valid); i++) begin
            @(posedge clock);
            #1;
        end
        repeat (3) @(posedge clock);
        #1;
        check({tag, "_pending"}, exp_q.size(), 0);
        check({tag, "_valid"}, {31'b0, bus.key_valid}, 0);
    endtask

    always @(negedge clock) begin
        if (resetn && bus.key_valid && bus.key_ready) begin
            if (exp_q.size() == 0) begin
                check("spurious_event_queue", exp_q.size(), 1);
            end else begin
                check("event", {24'b0, bus.key_ascii}, {24'b0, exp_q.pop_front()});
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        resetn         = 1'b0;
        bus.scan_data  = 8'h00;
        bus.scan_valid = 1'b0;
        bus.key_ready  = 1'b0;
        repeat (3) @(posedge clock);
        #1;
        check("rst_valid",    {31'b0, bus.key_valid},   0);
        check("rst_ascii",    {24'b0, bus.key_ascii},   0);
        check("rst_count",    {28'b0, bus.fifo_count},  0);
        check("rst_shift",    {31'b0, bus.shift_state}, 0);
        check("rst_caps",     {31'b0, bus.caps_state},  0);
        check("rst_overflow", {31'b0, bus.overflow},    0);
        resetn = 1'b1;
        @(posedge clock);
        #1;

        // Latency: scan at edge N, visible after N+1.
        send(8'h1C);
        @(negedge clock);
        check("lat_n_valid", {31'b0, bus.key_valid}, 0);
        @(negedge clock);
        check("lat_n1_valid", {31'b0, bus.key_valid}, 1);
        check("lat_n1_ascii", {24'b0, bus.key_ascii}, 32'h61);
        check("lat_n1_count", {28'b0, bus.fifo_count}, 1);
        @(posedge clock);
        #1;
        exp_q.push_back(8'h61);
        bus.key_ready = 1'b1;
        drain("lat");

        // Shift make/break and shifted letters/digits.
        send(8'h12);
        check("lshift_held", {31'b0, bus.shift_state}, 1);
        expect_send(8'h1C, 8'h41);
        expect_send(8'h16, 8'h21);
        expect_send(8'h45, 8'h29);
        send(8'hF0);
        send(8'h1C);
        send(8'hF0);
        send(8'h12);
        check("lshift_released", {31'b0, bus.shift_state}, 0);
        expect_send(8'h1C, 8'h61);
        send(8'h59);
        check("rshift_held", {31'b0, bus.shift_state}, 1);
        expect_send(8'h35, 8'h59);
        send(8'hF0);
        send(8'h59);
        check("rshift_released", {31'b0, bus.shift_state}, 0);
        drain("shift");

`ifdef PS2_CAPSLOCK_EN
        send(8'h58);
        check("caps_on", {31'b0, bus.caps_state}, 1);
        send(8'hF0);
        send(8'h58);
        check("caps_break_ignored", {31'b0, bus.caps_state}, 1);
        expect_send(8'h1C, 8'h41);
        send(8'h12);
        expect_send(8'h1C, 8'h61);
        send(8'hF0);
        send(8'h12);
        expect_send(8'h16, 8'h31);
        send(8'h58);
        check("caps_off", {31'b0, bus.caps_state}, 0);
`else
        send(8'h58);
        check("caps_disabled", {31'b0, bus.caps_state}, 0);
        expect_send(8'h1C, 8'h61);
`endif
        drain("caps");

        // Fixed codes, dropped codes, extended sequences.
        expect_send(8'h29, 8'h20);
        expect_send(8'h5A, 8'h0D);
        expect_send(8'h66, 8'h08);
        expect_send(8'h0D, 8'h09);
        expect_send(8'h76, 8'h1B);
        send(8'hAA);
        send(8'hFA);
        send(8'h05);
        send(8'hE0);
        expect_send(8'h75, 8'h80);
        send(8'hE0);
        send(8'hF0);
        send(8'h75);
        send(8'hE0);
        send(8'h11);
        send(8'hE0);
        expect_send(8'h6B, 8'h82);
        send(8'hE0);
        send(8'h12);
        check("ext_12_no_shift", {31'b0, bus.shift_state}, 0);
        drain("ext");

        // Overflow with consumer stalled.
        bus.key_ready = 1'b0;
        for (int i = 0; i < 9; i++) begin
            if (i < 8) exp_q.push_back(8'h61);
            send(8'h1C);
        end
        @(posedge clock);
        #1;
        check("ovf_count", {28'b0, bus.fifo_count}, 8);
        check("ovf_flag",  {31'b0, bus.overflow},   1);
        check("ovf_head",  {24'b0, bus.key_ascii},  32'h61);
        // Push and pop on the same edge while full.
        exp_q.push_back(8'h35 + 8'h2C);
        send(8'h1C);
        bus.key_ready = 1'b1;
        @(posedge clock);
        #1;
        bus.key_ready = 1'b0;
        check("full_pushpop_count", {28'b0, bus.fifo_count}, 8);
        check("full_pushpop_ovf",   {31'b0, bus.overflow},   1);
        bus.key_ready = 1'b1;
        drain("ovf");
        check("ovf_sticky", {31'b0, bus.overflow}, 1);

        // Reset between a break prefix and its code.
        send(8'hF0);
        resetn = 1'b0;
        @(posedge clock);
        #1;
        resetn = 1'b1;
        check("rst2_overflow", {31'b0, bus.overflow}, 0);
        check("rst2_count",    {28'b0, bus.fifo_count}, 0);
        expect_send(8'h1C, 8'h61);
        drain("midreset");

        $display("Result: errors=%0d of %0d checks", err_cnt, chk_cnt);
        $finish;
    end
endmodule

// File: doc/ps2_scancode_decoder.md
# ps2_scancode_decoder

Converts the raw PS/2 set-2 byte stream from the keyboard controller (byte plus one-cycle strobe) into ASCII key events. It tracks make/break/extended prefixes and shift/caps state, and buffers events in a small FIFO with a valid/ready handshake. It sits between the PS/2 interface and its consumers (processor keyboard port, LCD writer), replacing direct use of the raw last-byte output.

## Interface
- FIFO_DEPTH, 8, event FIFO entries; power of two, 2..64
- clock  in  1  system clock; every register is clocked on its rising edge
- resetn  in  1  synchronous active-low reset
- scan_data  in  8  received scancode byte
- scan_valid  in  1  one-cycle strobe, scan_data valid
- key_ascii  out  8  head-of-FIFO ASCII/event code; valid only while key_valid=1
- key_valid  out  1  FIFO not empty
- key_ready  in  1  consumer accepts head when key_valid=1
- shift_state  out  1  left (0x12) or right (0x59) shift currently held
- caps_state  out  1  caps-lock toggle state
- fifo_count  out  $clog2(FIFO_DEPTH)+1  entries held
- overflow  out  1  sticky: event dropped because FIFO was full

Clock and reset: one clock; reset is synchronous and active-low.

## Operation
- Prefix FSM states: IDLE, BRK (after 0xF0), EXT (after 0xE0), EXT_BRK (after 0xE0 0xF0). Transitions occur only on scan_valid.
  - IDLE: 0xF0→BRK; 0xE0→EXT; any other byte is a make code, processed, stays IDLE.
  - BRK: any byte is a break code, processed, →IDLE.
  - EXT: 0xF0→EXT_BRK; else extended make, →IDLE.
  - EXT_BRK: any byte is an extended break, →IDLE.
- Make 0x12/0x59 sets the respective shift bit; the matching break clears it. shift_state is the OR of the two bits. Shift codes emit no event.
- Make 0x58 toggles caps_state. Break 0x58 is ignored.
- Translated makes push one event:
  - Letters: lowercase, or uppercase when shift XOR caps.
  - Digits: '0'–'9'; with shift, ")!@#$%^&*(".
  - Fixed codes: 0x29→0x20, 0x5A→0x0D, 0x66→0x08, 0x0D→0x09, 0x76→0x1B.
  - Extended makes: 0x75→0x80, 0x72→0x81, 0x6B→0x82, 0x74→0x83.
- Dropped without an event: all other makes, all breaks, 0xAA, 0xFA, 0xEE, 0xFE.
- Typematic repeats are makes; each repeat pushes an event.
- FIFO is show-ahead. Pop occurs on a clock edge where key_valid & key_ready.
- Push while full: if a pop occurs on the same edge, both happen and count is unchanged. Otherwise the event is dropped, overflow←1, and FIFO contents are unchanged.
- Read/write pointers wrap modulo FIFO_DEPTH.

## Timing
- Reset values: FSM=IDLE, FIFO empty, key_valid=0, key_ascii=0x00, fifo_count=0, shift_state=0, caps_state=0, overflow=0.
- Reset mid-prefix discards the pending F0/E0.
- scan_valid at edge N → translated byte registered at N → FIFO write at N+1 → key_valid=1 after N+1. Latency is 2 clocks.
- shift_state/caps_state update at edge N.
- A translation at edge N uses shift/caps as they were before edge N.
- Pop at edge M: next entry (or key_valid=0) is visible after M. No bubble on back-to-back pops.
- A push into an empty FIFO on the same edge as no pop: visible the next cycle.
- Sustained throughput is one event per clock, far above the PS/2 byte rate.
- overflow clears only on reset.

## Configuration
- PS2_CAPSLOCK_EN defined: caps-lock tracking as above.
- PS2_CAPSLOCK_EN undefined: caps_state tied 0, 0x58 dropped like any unmapped code, letter case = shift_state only.

## Structure
- Shared package ps2_pkg holds:
  - prefix/special scancode constants (F0, E0, 12, 59, 58, AA, FA, EE, FE)
  - ASCII event constants (0x80–0x83 arrows, CR, BS, TAB, ESC, SPACE)
  - FSM state enum
- Sub-module ps2_key_fifo: parameterised sync FIFO with push/pop/full/empty/count.
- Translation is a combinational case function inside the top module.

## Test plan
- Reset, then scan 0x1C → key_ascii=0x61 two clocks later; key_ready=1 pops it; key_valid=0 after.
- 0x12, 0x1C, 0xF0, 0x1C, 0xF0, 0x12, 0x1C → events 0x41, 0x61; shift_state 1 then 0.
- (PS2_CAPSLOCK_EN) 0x58, 0xF0, 0x58, 0x12, 0x1C → caps_state=1, event 0x61; 0x16 alone → 0x31.
- 0xE0, 0x75, 0xE0, 0xF0, 0x75, 0xE0, 0x11 → single event 0x80.
- key_ready=0, nine makes 0x1C (FIFO_DEPTH=8) → fifo_count=8, overflow=1, eight 0x61 drained; push+pop on same edge while full → count stays 8, overflow unchanged.
- 0xF0 then resetn=0 one cycle, then 0x1C → event 0x61 (no break applied).
